// File: rtl/rv_register_file_pkg.sv
// Shared register-file constants and the register-index type,
// used by decode, writeback and the register file itself.
package rv_register_file_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage : rv_register_file_pkg

// File: rtl/rv_register_file_read_port.sv
// Combinational read port: selects one word from the register array,
// forcing index 0 to read as zero.
module rf_read_port #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    always_comb begin
        data = '0;
        if (addr != '0) begin
            data = regs[addr];
        end
    end

endmodule : rf_read_port

// File: rtl/rv_register_file.sv
// 32 x 64-bit integer register file: two combinational read ports,
// one synchronous write port, x0 hardwired to zero, async active-low reset.
module rv_register_file
    import rv_register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] r_19_15,
    input  logic [ADDR_WIDTH-1:0] r_24_10,
    input  logic [ADDR_WIDTH-1:0] r_11_7_w,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  regWr,
    output logic [DATA_WIDTH-1:0] read_data_one,
    output logic [DATA_WIDTH-1:0] read_data_two
);

    localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_WORDS];

    // No bypass: reads see the old value until the capturing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                regs[ADDR_WIDTH'(i)] <= '0;
            end
        end else if (regWr && (r_11_7_w != '0)) begin
            regs[r_11_7_w] <= write_data;
        end
    end

    rf_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_one (
        .regs(regs),
        .addr(r_19_15),
        .data(read_data_one)
    );

    rf_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_two (
        .regs(regs),
        .addr(r_24_10),
        .data(read_data_two)
    );

endmodule : rv_register_file

// File: tb/tb_rv_register_file.sv
// Self-checking bench for rv_register_file: a reference array supplies the
// expected read values, queued when addresses are driven and popped on compare.
module tb_rv_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  r_19_15;
    logic [4:0]  r_24_10;
    logic [4:0]  r_11_7_w;
    logic [63:0] write_data;
    logic        regWr;
    logic [63:0] read_data_one;
    logic [63:0] read_data_two;

    logic [63:0] model [32];
    logic [63:0] sb_q [$];
    int unsigned n_tests;
    int unsigned n_fail;

    rv_register_file #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r_19_15      (r_19_15),
        .r_24_10      (r_24_10),
        .r_11_7_w     (r_11_7_w),
        .write_data   (write_data),
        .regWr        (regWr),
        .read_data_one(read_data_one),
        .read_data_two(read_data_two)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [63:0] ref_read(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : model[a];
    endfunction

    task automatic expect_reads(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        r_19_15 = a1;
        r_24_10 = a2;
        sb_q.push_back(ref_read(a1));
        sb_q.push_back(ref_read(a2));
        #1;
        check_eq({tag, "/rs1"}, read_data_one, sb_q.pop_front());
        check_eq({tag, "/rs2"}, read_data_two, sb_q.pop_front());
    endtask

    task automatic do_write(input logic [4:0] rd, input logic [63:0] w, input logic we);
        @(negedge clk);
        r_11_7_w   = rd;
        write_data = w;
        regWr      = we;
        @(posedge clk);
        if (we && rd != 5'd0) model[rd] = w;
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        regWr = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        regWr      = 1'b0;
        r_19_15    = '0;
        r_24_10    = '0;
        r_11_7_w   = '0;
        write_data = '0;
        foreach (model[i]) model[i] = '0;

        // reset pulse; sweep every address on both ports while held
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            expect_reads($sformatf("reset_sweep[%0d]", i), 5'(i), 5'(31 - i));
        end
        @(negedge clk);
        rst_n = 1'b1;
        expect_reads("after_reset", 5'd7, 5'd31);

        // basic write held for three edges
        do_write(5'd2, 64'd2500, 1'b1);
        do_write(5'd2, 64'd2500, 1'b1);
        do_write(5'd2, 64'd2500, 1'b1);
        go_idle();
        expect_reads("basic_x2", 5'd2, 5'd0);
        expect_reads("untouched", 5'd1, 5'd3);

        // multi-register
        do_write(5'd19, 64'd2555, 1'b1);
        do_write(5'd31, 64'd2555, 1'b1);
        go_idle();
        expect_reads("multi_31_19", 5'd31, 5'd19);
        expect_reads("multi_19_2", 5'd19, 5'd2);

        // write disabled and x0 writes
        do_write(5'd5, 64'd7, 1'b0);
        expect_reads("wr_disabled_x5", 5'd5, 5'd2);
        do_write(5'd0, 64'hFFFF, 1'b1);
        go_idle();
        expect_reads("x0_write", 5'd0, 5'd0);

        // read during write: old value before the edge, new value after
        do_write(5'd3, 64'd10, 1'b1);
        @(negedge clk);
        r_11_7_w   = 5'd3;
        write_data = 64'd20;
        regWr      = 1'b1;
        expect_reads("rdw_before", 5'd3, 5'd3);
        @(posedge clk);
        model[3] = 64'd20;
        #1;
        expect_reads("rdw_after", 5'd3, 5'd19);
        go_idle();

        // boundary data patterns
        do_write(5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        do_write(5'd30, 64'hA5A5_5A5A_0123_4567, 1'b1);
        go_idle();
        expect_reads("all_ones_x1", 5'd1, 5'd30);

        // async reset mid-operation with a write pending
        @(negedge clk);
        r_11_7_w   = 5'd4;
        write_data = 64'd99;
        regWr      = 1'b1;
        #2 rst_n = 1'b0;
        foreach (model[i]) model[i] = '0;
        expect_reads("midrst_31_19", 5'd31, 5'd19);
        expect_reads("midrst_2_4", 5'd2, 5'd4);
        @(posedge clk);
        #1;
        expect_reads("midrst_edge_x4", 5'd4, 5'd2);
        @(negedge clk);
        regWr = 1'b0;
        rst_n = 1'b1;
        expect_reads("post_rst", 5'd4, 5'd1);

        // first write right after deassertion
        do_write(5'd4, 64'd123, 1'b1);
        go_idle();
        expect_reads("post_rst_write", 5'd4, 5'd30);

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rv_register_file
